softusb_hostif_mc: RTL and testbench

//  Host-side interface between the system CSR bus and the softusb navre core, single clock.

---
 rtl/softusb_hostif_mc_if.sv | 27 ++
 rtl/softusb_hostif_mc.sv | 156 +++++++++++++++
 tb/tb_softusb_hostif_mc.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/softusb_hostif_mc_if.sv
// Host/navre bus bundle for softusb_hostif_mc.
// CSR side, navre I/O side, irq and usb_rst.
interface softusb_hostif_mc_if;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        irq;
  logic        usb_rst;
  logic [5:0]  io_a;
  logic        io_we;
  logic        io_re;
  logic [7:0]  io_di;
  logic [7:0]  io_do;

  modport master (
    output csr_a, csr_we, csr_di,
    output io_a, io_we, io_re, io_di,
    input  csr_do, irq, usb_rst, io_do
  );

  modport slave (
    input  csr_a, csr_we, csr_di,
    input  io_a, io_we, io_re, io_di,
    output csr_do, irq, usb_rst, io_do
  );
endinterface

// File: rtl/softusb_hostif_mc.sv
// softusb host interface: CSR bank, navre reset,
// maskable IRQs and a host->USB byte mailbox FIFO.
module softusb_hostif_mc #(
  parameter logic [3:0] csr_addr   = 4'h0,
  parameter int         nirq       = 4,
  parameter int         fifo_depth = 16,
  parameter logic [5:0] io_base    = 6'h15
) (
  input logic sys_clk,
  input logic sys_rst,
  softusb_hostif_mc_if.slave bus
);

  localparam int AW = $clog2(fifo_depth);
  localparam int CW = AW + 1;
  localparam logic [5:0] IO_POP  = io_base + 6'd1;
  localparam logic [5:0] IO_STAT = io_base + 6'd2;
  localparam logic [CW-1:0] DEPTH = CW'(fifo_depth);

  logic            r_usb_rst;
  logic [nirq-1:0] r_pend;
  logic [nirq-1:0] r_mask;
  logic            r_irq;
  logic            r_ovf;
  logic [31:0]     r_csr_do;
  logic [7:0]      r_io_do;
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_wr;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_mem [fifo_depth];

  logic            w_sel;
  logic [2:0]      w_idx;
  logic            w_wr;
  logic [nirq-1:0] w_set;
  logic [nirq-1:0] w_clr;
  logic [CW-1:0]   w_cnt;
  logic [8:0]      w_cnt9;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_do_push;
  logic            w_do_pop;
  logic            w_ovf_set;
  logic            w_unused;

  assign w_sel = (bus.csr_a[13:10] == csr_addr);
  assign w_idx = bus.csr_a[2:0];
  assign w_wr  = w_sel && bus.csr_we;

  // FIFO reads as empty while the navre core is held in reset
  assign w_cnt   = r_usb_rst ? '0 : r_cnt;
  assign w_cnt9  = 9'(w_cnt);
  assign w_full  = (w_cnt == DEPTH);
  assign w_empty = (w_cnt == '0);

  assign w_push = w_wr && (w_idx == 3'd3);
  assign w_pop  = bus.io_re && (bus.io_a == IO_POP);

  assign w_do_pop  = w_pop && !w_empty && !r_usb_rst;
  assign w_do_push = w_push && !r_usb_rst && (!w_full || w_do_pop);
  assign w_ovf_set = w_push && !r_usb_rst && w_full && !w_pop;

  assign w_set = (bus.io_we && (bus.io_a == io_base) && !r_usb_rst)
               ? bus.io_di[nirq-1:0] : '0;
  assign w_clr = (w_wr && (w_idx == 3'd1)) ? bus.csr_di[nirq-1:0] : '0;

  assign w_unused = ^{bus.csr_a, bus.csr_di, bus.io_di};

  // Control, IRQ pending/mask and the irq output register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_usb_rst <= 1'b1;
      r_pend    <= '0;
      r_mask    <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr && (w_idx == 3'd0)) r_usb_rst <= bus.csr_di[0];
      if (w_wr && (w_idx == 3'd2)) r_mask <= bus.csr_di[nirq-1:0];
      r_pend <= (r_pend & ~w_clr) | w_set;
      r_irq  <= |(r_pend & r_mask);
    end
  end

  // Mailbox pointers, count and sticky overflow flag
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (r_usb_rst) begin
        r_rd  <= '0;
        r_wr  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_do_push) r_wr <= r_wr + AW'(1);
        if (w_do_pop)  r_rd <= r_rd + AW'(1);
        unique case ({w_do_push, w_do_pop})
          2'b10:   r_cnt <= r_cnt + CW'(1);
          2'b01:   r_cnt <= r_cnt - CW'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
      if (w_wr && (w_idx == 3'd4)) r_ovf <= 1'b0;
      else if (w_ovf_set)          r_ovf <= 1'b1;
    end
  end

  // Mailbox storage, no reset needed
  always_ff @(posedge sys_clk) begin
    if (w_do_push) r_mem[r_wr] <= bus.csr_di[7:0];
  end

  // Registered CSR read mux
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_csr_do <= '0;
    end else if (!w_sel) begin
      r_csr_do <= '0;
    end else begin
      unique case (w_idx)
        3'd0:    r_csr_do <= {31'b0, r_usb_rst};
        3'd1:    r_csr_do <= 32'(r_pend);
        3'd2:    r_csr_do <= 32'(r_mask);
        3'd4:    r_csr_do <= {8'b0, w_cnt9[7:0], 13'b0,
                              r_ovf, w_full, w_empty};
        default: r_csr_do <= '0;
      endcase
    end
  end

  // Registered navre I/O read mux, holds when no read
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_io_do <= '0;
    end else if (bus.io_re) begin
      unique case (1'b1)
        (bus.io_a == IO_POP):
          r_io_do <= w_do_pop ? r_mem[r_rd] : 8'h00;
        (bus.io_a == IO_STAT):
          r_io_do <= {6'b0, w_full, w_empty};
        default:
          r_io_do <= 8'h00;
      endcase
    end
  end

  assign bus.csr_do  = r_csr_do;
  assign bus.io_do   = r_io_do;
  assign bus.irq     = r_irq;
  assign bus.usb_rst = r_usb_rst;

endmodule

// File: tb/tb_softusb_hostif_mc.sv
// Directed scoreboard bench for softusb_hostif_mc.
// Expected bytes/words come from a bench-side FIFO model.
module tb_softusb_hostif_mc;

  localparam int DEPTH = 16;
  localparam logic [5:0] BASE = 6'h15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] sb[$];
  logic [7:0]  mq[$];
  logic        m_ovf = 1'b0;
  logic        m_usb = 1'b1;

  softusb_hostif_mc_if bus();

  softusb_hostif_mc dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus.csr_a  = '0;
    bus.csr_we = 1'b0;
    bus.csr_di = '0;
    bus.io_a   = '0;
    bus.io_we  = 1'b0;
    bus.io_re  = 1'b0;
    bus.io_di  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mstat_exp();
    logic [8:0] c;
    c = 9'(mq.size());
    return {8'b0, c[7:0], 13'b0, m_ovf,
            (mq.size() == DEPTH), (mq.size() == 0)};
  endfunction

  function automatic logic [7:0] model_pop();
    if (m_usb || mq.size() == 0) return 8'h00;
    return mq.pop_front();
  endfunction

  task automatic model_push(input logic [7:0] d, input bit pop_same);
    if (m_usb) return;
    if (mq.size() == DEPTH && !pop_same) m_ovf = 1'b1;
    else mq.push_back(d);
  endtask

  task automatic csr_wr(input logic [13:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.csr_a  = a;
    bus.csr_we = 1'b1;
    bus.csr_di = d;
    tick();
    idle_bus();
  endtask

  task automatic csr_rd(input string tag, input logic [13:0] a,
                        input logic [31:0] exp);
    sb.push_back(exp);
    @(negedge clk);
    bus.csr_a = a;
    tick();
    chk(tag, bus.csr_do, sb.pop_front());
    idle_bus();
  endtask

  task automatic ctrl_wr(input logic v);
    csr_wr(14'd0, {31'b0, v});
    m_usb = v;
    if (v) mq.delete();
  endtask

  task automatic push(input logic [7:0] d);
    model_push(d, 1'b0);
    csr_wr(14'd3, {24'b0, d});
  endtask

  task automatic io_rd(input string tag, input logic [5:0] a,
                       input logic [7:0] exp);
    sb.push_back({24'b0, exp});
    @(negedge clk);
    bus.io_a  = a;
    bus.io_re = 1'b1;
    tick();
    chk(tag, {24'b0, bus.io_do}, sb.pop_front());
    idle_bus();
  endtask

  task automatic pop(input string tag);
    io_rd(tag, BASE + 6'd1, model_pop());
  endtask

  task automatic push_pop(input string tag, input logic [7:0] d);
    sb.push_back({24'b0, model_pop()});
    model_push(d, 1'b1);
    @(negedge clk);
    bus.csr_a  = 14'd3;
    bus.csr_we = 1'b1;
    bus.csr_di = {24'b0, d};
    bus.io_a   = BASE + 6'd1;
    bus.io_re  = 1'b1;
    tick();
    chk(tag, {24'b0, bus.io_do}, sb.pop_front());
    idle_bus();
  endtask

  task automatic io_set(input logic [7:0] d);
    @(negedge clk);
    bus.io_a  = BASE;
    bus.io_we = 1'b1;
    bus.io_di = d;
    tick();
    idle_bus();
  endtask

  initial begin
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_usb_rst", {31'b0, bus.usb_rst}, 32'h1);
    chk("rst_irq", {31'b0, bus.irq}, 32'h0);
    chk("rst_csr_do", bus.csr_do, 32'h0);
    chk("rst_io_do", {24'b0, bus.io_do}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1: reset release
    csr_rd("t1_ctrl", 14'd0, 32'h1);
    csr_rd("t1_mstat", 14'd4, 32'h0000_0001);
    chk("t1_irq", {31'b0, bus.irq}, 32'h0);
    csr_rd("t1_unsel", 14'h0400, 32'h0);

    // 2: pending, mask, irq latency, W1C
    ctrl_wr(1'b0);
    csr_wr(14'd2, 32'h5);
    csr_rd("t2_mask", 14'd2, 32'h5);
    io_set(8'hFF);
    chk("t2_irq_lat", {31'b0, bus.irq}, 32'h0);
    tick();
    chk("t2_irq_set", {31'b0, bus.irq}, 32'h1);
    csr_rd("t2_pend", 14'd1, 32'hF);
    csr_wr(14'd1, 32'h5);
    csr_rd("t2_pend_clr", 14'd1, 32'hA);
    chk("t2_irq_clr", {31'b0, bus.irq}, 32'h0);

    // 3: set wins over same-cycle clear
    csr_wr(14'd1, 32'hF);
    @(negedge clk);
    bus.io_a   = BASE;
    bus.io_we  = 1'b1;
    bus.io_di  = 8'h01;
    bus.csr_a  = 14'd1;
    bus.csr_we = 1'b1;
    bus.csr_di = 32'h1;
    tick();
    idle_bus();
    csr_rd("t3_pend", 14'd1, 32'h1);
    chk("t3_irq", {31'b0, bus.irq}, 32'h1);
    csr_wr(14'd1, 32'h1);

    // 4: fill, overflow, drain, underflow
    for (int i = 0; i < DEPTH; i++) push(8'(8'h11 + i));
    csr_rd("t4_full", 14'd4, 32'h0010_0002);
    push(8'h99);
    csr_rd("t4_ovf", 14'd4, 32'h0010_0006);
    io_rd("t4_stat_full", BASE + 6'd2, 8'h02);
    for (int i = 0; i < DEPTH; i++) pop($sformatf("t4_pop%0d", i));
    pop("t4_pop_empty");
    csr_rd("t4_empty", 14'd4, 32'h0000_0005);
    io_rd("t4_stat_empty", BASE + 6'd2, 8'h01);
    csr_wr(14'd4, 32'h0);
    m_ovf = 1'b0;
    csr_rd("t4_ovf_clr", 14'd4, mstat_exp());
    io_rd("t4_other", BASE + 6'd3, 8'h00);

    // 5: push+pop while full, then while empty
    for (int i = 0; i < DEPTH; i++) push(8'(8'h30 + i));
    push_pop("t5_pp_full", 8'hAA);
    csr_rd("t5_mstat", 14'd4, 32'h0010_0002);
    for (int i = 0; i < DEPTH; i++) pop($sformatf("t5_pop%0d", i));
    push_pop("t5_pp_empty", 8'h5C);
    csr_rd("t5_cnt1", 14'd4, 32'h0001_0000);
    pop("t5_pop_5c");

    // 6: usb_rst flushes FIFO, drops pushes and IRQ sets
    push(8'h01);
    push(8'h02);
    push(8'h03);
    csr_rd("t6_cnt3", 14'd4, mstat_exp());
    ctrl_wr(1'b1);
    csr_rd("t6_flush", 14'd4, 32'h0000_0001);
    push(8'h44);
    csr_rd("t6_drop", 14'd4, 32'h0000_0001);
    pop("t6_pop_rst");
    io_set(8'h04);
    csr_rd("t6_pend_hold", 14'd1, 32'h0);
    csr_rd("t6_mask_hold", 14'd2, 32'h5);

    // async reset mid-operation
    ctrl_wr(1'b0);
    io_set(8'h01);
    push(8'h77);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("ar_usb_rst", {31'b0, bus.usb_rst}, 32'h1);
    chk("ar_csr_do", bus.csr_do, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_usb = 1'b1;
    csr_rd("ar_pend", 14'd1, 32'h0);
    csr_rd("ar_mask", 14'd2, 32'h0);
    csr_rd("ar_mstat", 14'd4, 32'h0000_0001);
    chk("ar_irq", {31'b0, bus.irq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
